// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller
package hazard_pkg;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} mdu_state_t;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-to-hazard-controller signal bundle
interface hazard_ctrl_if #(parameter int REG_LENGTH = 5, parameter int NUM_SRC = 2);
    logic [NUM_SRC-1:0][REG_LENGTH-1:0] rs_d, rs_e;
    logic [REG_LENGTH-1:0] rd_e, rd_m, rd_w;
    logic reg_write_e, reg_write_m, reg_write_w;
    logic [1:0] result_src_e;
    logic pc_src_e, mdu_start_e;
    logic [NUM_SRC-1:0][1:0] forward;
    logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy;
    modport master (
        output rs_d, rs_e, rd_e, rd_m, rd_w, reg_write_e, reg_write_m, reg_write_w,
               result_src_e, pc_src_e, mdu_start_e,
        input  forward, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy
    );
    modport slave (
        input  rs_d, rs_e, rd_e, rd_m, rd_w, reg_write_e, reg_write_m, reg_write_w,
               result_src_e, pc_src_e, mdu_start_e,
        output forward, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: single-operand forward select, Memory stage beats Writeback
module hazard_fwd_sel import hazard_pkg::*; #(parameter int REG_LENGTH = 5) (
    input  logic [REG_LENGTH-1:0] rs,
    input  logic [REG_LENGTH-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [REG_LENGTH-1:0] rd_w,
    input  logic                  reg_write_w,
    output fwd_sel_t              sel
);
    // x0 is never forwarded; the younger M result wins over W
    always_comb
        sel = (reg_write_m && rd_m == rs && rs != '0) ? FWD_M :
              (reg_write_w && rd_w == rs && rs != '0) ? FWD_W : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall, branch flush and MDU stall FSM; HAZARD_PERF_CNT_EN adds event counters
module hazard_ctrl import hazard_pkg::*; #(
    parameter int REG_LENGTH  = 5,
    parameter int NUM_SRC     = 2,
    parameter int MDU_LATENCY = 4
`ifdef HAZARD_PERF_CNT_EN
    , parameter int CNT_WIDTH = 32
`endif
) (
    input logic clk,
    input logic rst,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    , output logic [CNT_WIDTH-1:0] lu_stall_cnt
    , output logic [CNT_WIDTH-1:0] mdu_stall_cnt
    , output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);
    localparam int CW = $clog2(MDU_LATENCY);
    mdu_state_t state;
    logic [CW-1:0] cnt;
    logic [NUM_SRC-1:0][1:0] fwd;
    logic hit, lu, mdu_stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        hazard_fwd_sel #(.REG_LENGTH(REG_LENGTH)) u_sel (
            .rs(hz.rs_e[i]), .rd_m(hz.rd_m), .reg_write_m(hz.reg_write_m),
            .rd_w(hz.rd_w), .reg_write_w(hz.reg_write_w), .sel(fwd[i])
        );
    end

    // Load-use: a load in E whose rd feeds any D-stage source needs one bubble
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) hit |= hz.rs_d[i] == hz.rd_e;
        lu = hz.result_src_e == RESULT_SRC_LOAD && hz.reg_write_e && hz.rd_e != '0 && hit;
        mdu_stall = state == BUSY || (state == IDLE && hz.mdu_start_e);
    end

    // MDU hold FSM; DONE is the op's final E cycle, so a still-high start there is ignored
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else
            unique case (state)
                IDLE: if (hz.mdu_start_e) begin
                    cnt   <= CW'(MDU_LATENCY - 2);
                    state <= MDU_LATENCY == 2 ? DONE : BUSY;
                end
                BUSY: if (cnt == CW'(1)) state <= DONE; else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase

    // Branch dominates stalls; ID/EX is never cleared while it is being held
    always_comb begin
        hz.forward  = rst ? '0 : fwd;
        hz.stall_f  = !rst && (lu || mdu_stall) && !hz.pc_src_e;
        hz.stall_d  = hz.stall_f;
        hz.stall_e  = !rst && mdu_stall;
        hz.flush_m  = hz.stall_e;
        hz.flush_d  = !rst && hz.pc_src_e;
        hz.flush_e  = !rst && (hz.pc_src_e || (lu && !mdu_stall));
        hz.mdu_busy = !rst && state != IDLE;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters for load-use, MDU stall and branch flush cycles
    always_ff @(posedge clk)
        if (rst) begin
            lu_stall_cnt  <= '0;
            mdu_stall_cnt <= '0;
            flush_cnt     <= '0;
        end else begin
            lu_stall_cnt  <= lu_stall_cnt  + CNT_WIDTH'(lu && !(&lu_stall_cnt));
            mdu_stall_cnt <= mdu_stall_cnt + CNT_WIDTH'(mdu_stall && !(&mdu_stall_cnt));
            flush_cnt     <= flush_cnt     + CNT_WIDTH'(hz.pc_src_e && !(&flush_cnt));
        end
`endif
endmodule
